// File: rtl/uart_16550_host.sv
// uart_16550_host
//   Register-level host for a 16550-style UART. After reset it programs
//   LCR, FCR and IER. It then polls LSR forever and moves bytes between
//   the UART and two valid/ready streams: a one-byte TX holding register
//   in front of THR, and a one-byte RX output register fed from RBR.
//
// Ports
//   clk, reset          : sole clock (rising edge), async active-high reset
//   s_tx_valid/ready    : byte stream into the TX holding register
//   s_tx_data [7:0]
//   m_rx_valid/ready    : received byte stream out of the RBR reads
//   m_rx_data [7:0]
//   req_valid/ready     : register access handshake to the UART responder
//   req_addr  [2:0]       (register offset), req_we (1 = write),
//   req_wdata [7:0]       write data, req_rdata [7:0] combinational read data
//   init_done           : init sequence finished, holds until reset
//   bus_err             : sticky, some access timed out
//   rx_err              : sticky, an LSR read returned bit 7 set
module uart_16550_host #(
    parameter logic [7:0] INIT_LCR = 8'h03,
    parameter logic [7:0] INIT_FCR = 8'h01,
    parameter logic [7:0] INIT_IER = 8'h00,
    parameter int         POLL_GAP = 4,
    parameter int         TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tx_valid,
    input  logic [7:0] s_tx_data,
    output logic       s_tx_ready,
    output logic       m_rx_valid,
    output logic [7:0] m_rx_data,
    input  logic       m_rx_ready,
    output logic       req_valid,
    output logic [2:0] req_addr,
    output logic [7:0] req_wdata,
    output logic       req_we,
    input  logic       req_ready,
    input  logic [7:0] req_rdata,
    output logic       init_done,
    output logic       bus_err,
    output logic       rx_err
);

    typedef enum logic [2:0] {
        ST_INIT_LCR, ST_INIT_FCR, ST_INIT_IER, ST_POLL_LSR,
        ST_DECIDE,   ST_WR_THR,   ST_RD_RBR,   ST_GAP
    } state_t;

    // Access substates: START issues the first access after reset, REQ
    // holds req_valid until req_ready or timeout, ACK is the second valid
    // cycle, IDLE is the mandatory req_valid=0 cycle between accesses.
    typedef enum logic [1:0] {SUB_START, SUB_REQ, SUB_ACK, SUB_IDLE} sub_t;

    typedef enum logic {SIDE_RX = 1'b0, SIDE_TX = 1'b1} side_t;

    localparam int              WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [7:0]      GAP_LAST  = 8'(POLL_GAP - 1);

    state_t         state, succ;
    sub_t           sub;
    side_t          last_served;
    logic           advance;
    logic [WCW-1:0] wait_cnt;
    logic [7:0]     gap_cnt;
    logic [7:0]     tx_hold;
    logic           tx_hold_full;
    logic           lsr_thre;   // LSR[5] from the latest poll
    logic           lsr_dr;     // LSR[0] from the latest poll
    logic           tx_elig, rx_elig;

    function automatic logic is_access(state_t s);
        return (s != ST_DECIDE) && (s != ST_GAP);
    endfunction

    function automatic logic [2:0] access_addr(state_t s);
        case (s)
            ST_INIT_LCR: return 3'd3;
            ST_INIT_FCR: return 3'd2;
            ST_INIT_IER: return 3'd1;
            ST_POLL_LSR: return 3'd5;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] access_wdata(state_t s, logic [7:0] thr_byte);
        case (s)
            ST_INIT_LCR: return INIT_LCR;
            ST_INIT_FCR: return INIT_FCR;
            ST_INIT_IER: return INIT_IER;
            ST_WR_THR:   return thr_byte;
            default:     return 8'h00;
        endcase
    endfunction

    // Reset forces ready low without waiting for a clock edge.
    assign s_tx_ready = !reset && !tx_hold_full;

    assign tx_elig = lsr_thre && tx_hold_full;
    assign rx_elig = lsr_dr && !m_rx_valid;

    // Successor selection; advance marks the edge at which state moves on
    // (and, for access states, the next access is launched).
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        advance = 1'b0;
        succ    = state;
        case (state)
            ST_DECIDE: begin
                advance = 1'b1;
                if (tx_elig && rx_elig)
                    succ = (last_served == SIDE_TX) ? ST_RD_RBR : ST_WR_THR;
                else if (tx_elig)
                    succ = ST_WR_THR;
                else if (rx_elig)
                    succ = ST_RD_RBR;
                else
                    succ = (POLL_GAP == 0) ? ST_POLL_LSR : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    advance = 1'b1;
                    succ    = ST_POLL_LSR;
                end
            end
            default: begin
                if (sub == SUB_START) begin
                    advance = 1'b1;
                end else if (sub == SUB_IDLE) begin
                    advance = 1'b1;
                    case (state)
                        ST_INIT_LCR: succ = ST_INIT_FCR;
                        ST_INIT_FCR: succ = ST_INIT_IER;
                        ST_POLL_LSR: succ = ST_DECIDE;
                        default:     succ = ST_POLL_LSR;  // IER, THR, RBR
                    endcase
                end
            end
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_INIT_LCR;
            sub          <= SUB_START;
            last_served  <= SIDE_RX;
            wait_cnt     <= '0;
            gap_cnt      <= 8'h00;
            tx_hold      <= 8'h00;
            tx_hold_full <= 1'b0;
            lsr_thre     <= 1'b0;
            lsr_dr       <= 1'b0;
            req_valid    <= 1'b0;
            req_addr     <= 3'd0;
            req_wdata    <= 8'h00;
            req_we       <= 1'b0;
            m_rx_valid   <= 1'b0;
            m_rx_data    <= 8'h00;
            init_done    <= 1'b0;
            bus_err      <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            // Stream handshakes run in every state. The FSM only clears
            // tx_hold_full while it is set and only sets m_rx_valid while it
            // is clear, so these never collide with the FSM updates.
            if (s_tx_valid && s_tx_ready) begin
                tx_hold      <= s_tx_data;
                tx_hold_full <= 1'b1;
            end
            if (m_rx_valid && m_rx_ready)
                m_rx_valid <= 1'b0;

            if (advance) begin
                state <= succ;
                if (is_access(succ)) begin
                    req_valid <= 1'b1;
                    req_addr  <= access_addr(succ);
                    req_we    <= (succ != ST_POLL_LSR) && (succ != ST_RD_RBR);
                    req_wdata <= access_wdata(succ, tx_hold);
                    sub       <= SUB_REQ;
                    wait_cnt  <= '0;
                end
                if (succ == ST_GAP)
                    gap_cnt <= 8'h00;
                if (succ == ST_WR_THR)
                    last_served <= SIDE_TX;
                if (succ == ST_RD_RBR)
                    last_served <= SIDE_RX;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                case (sub)
                    SUB_REQ: begin
                        if (req_ready) begin
                            sub <= SUB_ACK;
                            case (state)
                                ST_POLL_LSR: begin
                                    lsr_thre <= req_rdata[5];
                                    lsr_dr   <= req_rdata[0];
                                    if (req_rdata[7])
                                        rx_err <= 1'b1;
                                end
                                ST_RD_RBR: m_rx_data    <= req_rdata;
                                ST_WR_THR: tx_hold_full <= 1'b0;
                                default: ;
                            endcase
                        end else if (wait_cnt == WAIT_LAST) begin
                            // Abandon the access; a timed-out poll reads as
                            // "no work" and a timed-out THR keeps its byte.
                            req_valid <= 1'b0;
                            bus_err   <= 1'b1;
                            sub       <= SUB_IDLE;
                            if (state == ST_POLL_LSR) begin
                                lsr_thre <= 1'b0;
                                lsr_dr   <= 1'b0;
                            end
                            if (state == ST_INIT_IER)
                                init_done <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    SUB_ACK: begin
                        req_valid <= 1'b0;
                        sub       <= SUB_IDLE;
                        if (state == ST_RD_RBR)
                            m_rx_valid <= 1'b1;
                        if (state == ST_INIT_IER)
                            init_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_16550_host.sv
// tb_uart_16550_host
//   Directed bench for uart_16550_host with default parameters. A small
//   responder model answers register accesses (LSR and RBR values set by
//   the stimulus, THR writes optionally never acknowledged) and a monitor
//   records every completed access with its valid-cycle length.
module tb_uart_16550_host;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tx_valid;
    logic [7:0] s_tx_data;
    logic       s_tx_ready;
    logic       m_rx_valid;
    logic [7:0] m_rx_data;
    logic       m_rx_ready;
    logic       req_valid;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_we;
    logic       req_ready;
    logic [7:0] req_rdata;
    logic       init_done;
    logic       bus_err;
    logic       rx_err;

    logic [7:0] lsr_val;
    logic [7:0] rbr_val;
    logic       block_thr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] addr;
        logic       we;
        logic [7:0] wdata;
        int         len;
    } acc_t;

    acc_t acc_q[$];

    uart_16550_host dut (
        .clk        (clk),
        .reset      (reset),
        .s_tx_valid (s_tx_valid),
        .s_tx_data  (s_tx_data),
        .s_tx_ready (s_tx_ready),
        .m_rx_valid (m_rx_valid),
        .m_rx_data  (m_rx_data),
        .m_rx_ready (m_rx_ready),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .req_ready  (req_ready),
        .req_rdata  (req_rdata),
        .init_done  (init_done),
        .bus_err    (bus_err),
        .rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    // Zero-wait responder; THR writes can be left unacknowledged.
    assign req_ready = req_valid && !(block_thr && req_addr == 3'd0 && req_we);
    assign req_rdata = (req_addr == 3'd5) ? lsr_val :
                       (req_addr == 3'd0) ? rbr_val : 8'h00;

    // Access monitor, sampled on the falling edge.
    logic       vld_q;
    int         run;
    logic [2:0] cur_addr;
    logic       cur_we;
    logic [7:0] cur_wdata;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            run   <= 0;
        end else begin
            if (req_valid) begin
                if (!vld_q) begin
                    cur_addr  <= req_addr;
                    cur_we    <= req_we;
                    cur_wdata <= req_wdata;
                    run       <= 1;
                end else begin
                    run <= run + 1;
                end
            end else if (vld_q) begin
                acc_q.push_back('{addr: cur_addr, we: cur_we, wdata: cur_wdata, len: run});
            end
            vld_q <= req_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic get_acc(output acc_t a);
        int n = 0;
        a = '{addr: 3'd7, we: 1'b0, wdata: 8'h00, len: 0};
        while (acc_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("access_seen", 32'(acc_q.size() != 0), 1);
        if (acc_q.size() != 0)
            a = acc_q.pop_front();
    endtask

    // Next access that is not an LSR poll.
    task automatic get_op(output acc_t a);
        int n = 0;
        get_acc(a);
        while (a.addr == 3'd5 && !a.we && n < 40) begin
            get_acc(a);
            n++;
        end
    endtask

    task automatic expect_acc(input string tag, input acc_t a, input logic [2:0] addr,
                              input logic we, input logic [7:0] wdata, input int len);
        check({tag, "_addr"},  32'(a.addr),  32'(addr));
        check({tag, "_we"},    32'(a.we),    32'(we));
        check({tag, "_wdata"}, 32'(a.wdata), 32'(wdata));
        check({tag, "_len"},   32'(a.len),   32'(len));
    endtask

    task automatic send_tx(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_pre", 32'(s_tx_ready), 1);
        s_tx_valid = 1'b1;
        s_tx_data  = b;
        @(negedge clk);
        s_tx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"},  32'(req_valid),  0);
        check({tag, "_req_we"},     32'(req_we),     0);
        check({tag, "_req_addr"},   32'(req_addr),   0);
        check({tag, "_req_wdata"},  32'(req_wdata),  0);
        check({tag, "_m_rx_valid"}, 32'(m_rx_valid), 0);
        check({tag, "_m_rx_data"},  32'(m_rx_data),  0);
        check({tag, "_init_done"},  32'(init_done),  0);
        check({tag, "_bus_err"},    32'(bus_err),    0);
        check({tag, "_rx_err"},     32'(rx_err),     0);
        check({tag, "_s_tx_ready"}, 32'(s_tx_ready), 0);
    endtask

    task automatic check_init(input string tag);
        acc_t a;
        get_acc(a);
        expect_acc({tag, "_lcr"}, a, 3'd3, 1'b1, 8'h03, 2);
        check({tag, "_done_early"}, 32'(init_done), 0);
        get_acc(a);
        expect_acc({tag, "_fcr"}, a, 3'd2, 1'b1, 8'h01, 2);
        get_acc(a);
        expect_acc({tag, "_ier"}, a, 3'd1, 1'b1, 8'h00, 2);
        check({tag, "_done"}, 32'(init_done), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        acc_t a;
        int   polls;
        int   others;
        int   n;

        s_tx_valid = 1'b0;
        s_tx_data  = 8'h00;
        m_rx_ready = 1'b0;
        lsr_val    = 8'h60;
        rbr_val    = 8'h00;
        block_thr  = 1'b0;
        reset      = 1'b1;

        // Reset values and init sequence
        #1;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("tx_ready_after_rst", 32'(s_tx_ready), 1);
        check_init("init");

        // TX byte goes to THR after an LSR poll
        send_tx(8'h41);
        check("tx_ready_held", 32'(s_tx_ready), 0);
        get_op(a);
        expect_acc("thr41", a, 3'd0, 1'b1, 8'h41, 2);
        check("tx_ready_freed", 32'(s_tx_ready), 1);

        // RX byte held while unconsumed; no further RBR reads
        rbr_val = 8'h5A;
        lsr_val = 8'h61;
        get_op(a);
        expect_acc("rbr5a", a, 3'd0, 1'b0, 8'h00, 2);
        repeat (2) @(negedge clk);
        check("rx_valid_5a", 32'(m_rx_valid), 1);
        check("rx_data_5a", 32'(m_rx_data), 'h5A);
        acc_q.delete();
        repeat (80) @(negedge clk);
        polls  = 0;
        others = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i].addr == 3'd5 && !acc_q[i].we) polls++;
            else others++;
        end
        check("rbr_blocked", 32'(others), 0);
        check("polls_continue", 32'(polls >= 5), 1);
        check("rx_data_held", 32'(m_rx_data), 'h5A);
        check("rx_valid_held", 32'(m_rx_valid), 1);
        rbr_val = 8'h33;
        acc_q.delete();
        m_rx_ready = 1'b1;
        @(negedge clk);
        m_rx_ready = 1'b0;
        check("rx_consumed", 32'(m_rx_valid), 0);
        get_op(a);
        expect_acc("rbr33", a, 3'd0, 1'b0, 8'h00, 2);
        repeat (2) @(negedge clk);
        check("rx_data_33", 32'(m_rx_data), 'h33);

        // Both eligible with last_served = TX: RBR, poll, THR
        send_tx(8'h77);
        get_op(a);
        expect_acc("thr77", a, 3'd0, 1'b1, 8'h77, 2);
        rbr_val = 8'h5B;
        @(negedge clk);
        check("tx_ready_pre_both", 32'(s_tx_ready), 1);
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h78;
        m_rx_ready = 1'b1;
        @(negedge clk);
        s_tx_valid = 1'b0;
        m_rx_ready = 1'b0;
        check("both_tx_taken", 32'(s_tx_ready), 0);
        check("both_rx_taken", 32'(m_rx_valid), 0);
        get_op(a);
        expect_acc("both_rbr", a, 3'd0, 1'b0, 8'h00, 2);
        get_acc(a);
        expect_acc("both_poll", a, 3'd5, 1'b0, 8'h00, 2);
        get_acc(a);
        expect_acc("both_thr", a, 3'd0, 1'b1, 8'h78, 2);
        check("rx_data_5b", 32'(m_rx_data), 'h5B);

        // THR write times out, byte retained and retried
        check("bus_err_clean", 32'(bus_err), 0);
        block_thr = 1'b1;
        send_tx(8'h99);
        get_op(a);
        expect_acc("thr_to1", a, 3'd0, 1'b1, 8'h99, TIMEOUT);
        check("bus_err_set", 32'(bus_err), 1);
        check("tx_retained", 32'(s_tx_ready), 0);
        get_op(a);
        expect_acc("thr_to2", a, 3'd0, 1'b1, 8'h99, TIMEOUT);
        block_thr = 1'b0;
        get_op(a);
        expect_acc("thr_retry", a, 3'd0, 1'b1, 8'h99, 2);
        @(negedge clk);
        check("tx_ready_retry", 32'(s_tx_ready), 1);
        check("bus_err_sticky", 32'(bus_err), 1);

        // LSR bit 7 sets sticky rx_err
        check("rx_err_clean", 32'(rx_err), 0);
        lsr_val = 8'hE1;
        acc_q.delete();
        get_acc(a);
        get_acc(a);
        expect_acc("poll_e1", a, 3'd5, 1'b0, 8'h00, 2);
        check("rx_err_set", 32'(rx_err), 1);
        lsr_val = 8'h60;
        acc_q.delete();
        repeat (3) get_acc(a);
        check("rx_err_sticky", 32'(rx_err), 1);

        // Reset in the middle of a THR write
        block_thr = 1'b1;
        send_tx(8'hA5);
        n = 0;
        while (!(req_valid && req_addr == 3'd0 && req_we) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("thr_in_flight", 32'(req_valid && req_addr == 3'd0 && req_we), 1);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        acc_q.delete();
        block_thr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("tx_ready_rerun", 32'(s_tx_ready), 1);
        check_init("reinit");
        check("bus_err_after_rst", 32'(bus_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_16550_host.md
UART_16550_HOST -- requirements
Module: uart_16550_host

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- INIT_LCR, 8'h03, value written to LCR during init (8N1).
- INIT_FCR, 8'h01, value written to FCR during init (FIFO enable).
- INIT_IER, 8'h00, value written to IER during init.
- POLL_GAP, 4, idle cycles inserted after an LSR poll that yields no work; range 0..255.
- TIMEOUT, 16, cycles to wait for req_ready before aborting an access; minimum 2.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- s_tx_valid, in, 1, byte to transmit is valid.
- s_tx_data, in, 8, byte to transmit.
- s_tx_ready, out, 1, internal TX holding register is empty.
- m_rx_valid, out, 1, received byte is valid.
- m_rx_data, out, 8, received byte.
- m_rx_ready, in, 1, consumer accepts the received byte.
- req_valid, out, 1, register access request.
- req_addr, out, 3, UART register offset.
- req_wdata, out, 8, write data.
- req_we, out, 1, 1 = write, 0 = read.
- req_ready, in, 1, responder has completed the access.
- req_rdata, in, 8, combinational read data from the responder.
- init_done, out, 1, init sequence is complete.
- bus_err, out, 1, sticky flag: an access timed out.
- rx_err, out, 1, sticky flag: LSR[7] was seen set.

REQ-003 The single clock SHALL be clk and the reset SHALL be reset, asynchronous and active-high; there are no other clocks or resets.

Function
REQ-004 Access timing: assert req_valid with req_addr, req_we and req_wdata stable; hold until req_ready is sampled 1; deassert in the following cycle; keep req_valid=0 for at least 1 cycle between accesses.
REQ-005 Read data SHALL be captured from req_rdata at the clock edge that ends the first cycle of req_valid. With a zero-wait responder, an access spans 2 valid cycles plus 1 idle cycle.
REQ-006 Timeout: if req_ready is not seen within TIMEOUT cycles of req_valid rising, the block SHALL drop req_valid, set bus_err, discard any read data, and continue at the next scheduled step. A timed-out THR write SHALL keep its byte for retry.
REQ-007 FSM states SHALL be INIT_LCR, INIT_FCR, INIT_IER, POLL_LSR, DECIDE, WR_THR, RD_RBR and GAP. Every access state uses an issue/wait substate followed by the mandatory idle cycle.
REQ-008 Init SHALL write, in order, LCR (addr 3) = INIT_LCR, FCR (addr 2) = INIT_FCR, then IER (addr 1) = INIT_IER. init_done SHALL go to 1 in the cycle after the IER access completes and stay 1 until reset.
REQ-009 TX holding register:
- s_tx_ready = !tx_hold_full.
- A byte is latched when s_tx_valid && s_tx_ready.
- tx_hold_full clears only on successful completion of a THR write.
REQ-010 Main loop: POLL_LSR reads addr 5, then DECIDE evaluates:
- tx_elig = LSR[5] && tx_hold_full.
- rx_elig = LSR[0] && !m_rx_valid.
REQ-011 DECIDE outcomes:
- Exactly one eligible: perform that access.
- Both eligible: serve the side not served last; a 1-bit last_served flag resets to RX, so TX is served first after reset.
- Neither eligible: GAP for POLL_GAP cycles (0 = none), then POLL_LSR.
REQ-012 After WR_THR or RD_RBR the block SHALL return directly to POLL_LSR; it never issues THR/RBR accesses without a fresh LSR poll.
REQ-013 WR_THR SHALL write addr 0 with req_wdata = tx_hold.
REQ-014 RD_RBR SHALL read addr 0 and load m_rx_data; m_rx_valid SHALL be set in the following cycle. m_rx_valid and m_rx_data SHALL hold until m_rx_valid && m_rx_ready, then clear m_rx_valid.
REQ-015 The block SHALL never overwrite an unconsumed m_rx byte; UART backpressure occurs by leaving data in the UART FIFO.
REQ-016 rx_err SHALL set whenever a captured LSR value has bit 7 = 1; rx_err and bus_err clear only on reset.
REQ-017 s_tx acceptance and m_rx consumption SHALL be accepted in any FSM state, including during init and GAP.

Reset
REQ-018 While reset = 1, all outputs SHALL take these values immediately, asynchronously:
- req_valid = 0, req_we = 0, req_addr = 0, req_wdata = 0.
- m_rx_valid = 0, m_rx_data = 0.
- init_done = 0, bus_err = 0, rx_err = 0.
- s_tx_ready = 0.
REQ-019 On reset release: FSM = INIT_LCR, tx_hold_full = 0, last_served = RX, GAP counter = 0; s_tx_ready = 1 from the first cycle after release. Reset mid-access SHALL abandon the access and re-run init.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset release, zero-wait responder -> writes (3, 0x03), (2, 0x01), (1, 0x00), each 2 valid cycles + 1 idle; init_done=1 after the third access.
- s_tx 0x41 accepted, LSR returns 0x60 -> next access writes addr 0 with 0x41; s_tx_ready=0 until that write completes, then 1.
- LSR 0x61, RBR returns 0x5A, m_rx_ready=0 -> m_rx_valid=1 with data 0x5A held; subsequent polls return 0x61 but issue no RBR read until the byte is consumed.
- Both eligible, last_served=TX -> RBR read, then poll, then THR write.
- req_ready never asserted -> req_valid drops after TIMEOUT cycles, bus_err=1, THR byte retained and retried.
- LSR 0xE1 -> rx_err=1 and stays 1; reset asserted during a THR write -> req_valid=0 in the same cycle, init sequence repeats.
